rcr_write_arbiter: RTL

RCR_WRITE_ARBITER -- requirements
Module: rcr_write_arbiter

---
 rtl/rcr_write_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rcr_write_arbiter.sv
// ---------------------------------------------------------------------------
// rcr_write_arbiter
//
// Collects event bits from NUM_REQ I/O-side sources into per-source pending
// buffers. It then forwards them one word at a time to the I/O write port of a
// shared read-clear register. The register's clock-domain-crossing handshake
// reports progress through IO_Busy. Sources are served round-robin. Events
// that arrive while a source's word is still waiting are OR-merged into that
// word and flagged in Merged.
//
// Ports
//   Clock       in   I/O-domain clock
//   Reset       in   asynchronous, active-low reset
//   Req_Valid   in   [NUM_REQ]            per-source one-cycle event strobe
//   Req_Data    in   [NUM_REQ*DATA_WIDTH] per-source event bits, slice i
//   IO_WrData   out  [DATA_WIDTH]         word for the register write port
//   IO_WrEn     out  one-cycle write-start pulse
//   IO_Busy     in   handshake busy flag from the register
//   Pending     out  [NUM_REQ]            source i holds unsent bits
//   Merged      out  [NUM_REQ]            sticky: source i strobed while pending
//   Merged_Clr  in   one-cycle pulse clearing all Merged bits
// ---------------------------------------------------------------------------
module rcr_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            Req_Valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
    output logic [DATA_WIDTH-1:0]         IO_WrData,
    output logic                          IO_WrEn,
    input  logic                          IO_Busy,
    output logic [NUM_REQ-1:0]            Pending,
    output logic [NUM_REQ-1:0]            Merged,
    input  logic                          Merged_Clr
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arbState;

    arbState               state;
    logic [PTR_W-1:0]      rrPtr;
    logic [DATA_WIDTH-1:0] pendBuf [NUM_REQ];

    logic                  grantValid;
    logic [PTR_W-1:0]      grantIdx;
    logic                  startGrant;
    logic [NUM_REQ-1:0]    reqHit;
    logic [NUM_REQ-1:0]    grantHot;
    logic [NUM_REQ-1:0]    mergedSet;

    // Strobes with an all-zero slice carry no events and are ignored entirely.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        reqHit  = '0;
        Pending = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqHit[i]  = Req_Valid[i] && (Req_Data[i*DATA_WIDTH +: DATA_WIDTH] != '0);
            Pending[i] = (pendBuf[i] != '0);
        end
    end

    // Round-robin pick: first pending source at or after rrPtr, wrapping.
    always_comb begin
        int cand;
        cand       = 0;
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rrPtr) + k) % NUM_REQ;
            if (!grantValid && Pending[cand]) begin
                grantValid = 1'b1;
                grantIdx   = PTR_W'(cand);
            end
        end
    end

    assign startGrant = (state == IDLE) && grantValid && !IO_Busy;

    // A strobe landing on the buffer being latched must not be counted as a
    // merge: its bits go into the freshly cleared buffer as a new word.
    always_comb begin
        grantHot  = '0;
        mergedSet = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grantHot[i]  = startGrant && (int'(grantIdx) == i);
            mergedSet[i] = reqHit[i] && Pending[i] && !grantHot[i];
        end
    end

    // NOTE: the buffer array is state that must never hold stale events after
    // reset, so unlike a data RAM every entry is cleared by the reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pendBuf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grantHot[i]) begin
                    pendBuf[i] <= reqHit[i] ? Req_Data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                end else if (reqHit[i]) begin
                    pendBuf[i] <= pendBuf[i] | Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Set is ORed in after the clear, so a simultaneous set wins.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Merged <= '0;
        end else begin
            Merged <= (Merged & ~{NUM_REQ{Merged_Clr}}) | mergedSet;
        end
    end

    // Transfer FSM. IO_WrData is only loaded on the IDLE->ISSUE edge, so it
    // stays stable through the whole handshake.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            rrPtr     <= '0;
            IO_WrEn   <= 1'b0;
            IO_WrData <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (startGrant) begin
                        IO_WrData <= pendBuf[grantIdx];
                        IO_WrEn   <= 1'b1;
                        if (int'(grantIdx) == NUM_REQ - 1) begin
                            rrPtr <= '0;
                        end else begin
                            rrPtr <= grantIdx + 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    IO_WrEn <= 1'b0;
                    state   <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (IO_Busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!IO_Busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    IO_WrEn <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
